div_unit: RTL and testbench

Sequential signed 32-bit divider that sits directly downstream of the control unit in the multicycle CPU datapath. It consumes `div_start` together with operands A/B and produces the quotient (LO), the remainder (HI) and the `divzero` exception flag that the control unit samples. It uses restoring division, one quotient bit per clock. The control unit holds in its DIV wait state until `div_done`, then writes HI/LO.

---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- sequential signed divider (restoring, one quotient bit per clock)
//
// Sits downstream of the multicycle CPU control unit. A request accepted in
// IDLE runs WIDTH iterations on operand magnitudes, then a single FIX cycle
// restores the signs (quotient truncates toward zero, remainder takes the
// sign of the dividend, as MIPS DIV does).
//
// Handshake: div_start is sampled only in IDLE. An accepted request with a
// non-zero divisor raises div_busy from the accepting edge until the edge on
// which hi/lo update, where div_done pulses for one cycle. A zero divisor
// produces a one-cycle divzero pulse instead and leaves hi/lo untouched.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   div_start  in   division request
//   dividend   in   signed dividend, sampled on the accepting edge
//   divisor    in   signed divisor, sampled on the accepting edge
//   hi         out  remainder of the last completed division
//   lo         out  quotient of the last completed division
//   div_busy   out  high while a division is in progress (RUN, FIX)
//   div_done   out  one-cycle completion pulse
//   divzero    out  one-cycle pulse on a start with divisor == 0
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_busy,
    output logic             div_done,
    output logic             divzero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    // Shifted partial remainder and trial difference. One extra top bit on the
    // difference acts as the borrow: set means the trial went negative.
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;

    assign rem_sh       = {rem_q, quo_q[WIDTH-1]};
    assign trial        = rem_sh - {2'b00, mag_q};
    // |most negative| wraps to itself, which is the correct unsigned magnitude.
    assign dividend_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign divisor_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            mag_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            mag_q   <= mag_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        mag_d   = mag_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    if (divisor == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        quo_d   = dividend_abs;
                        mag_d   = divisor_abs;
                        sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sr_d    = dividend[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                // cnt_q counts completed iterations; this cycle is the last one.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = sq_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = sr_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_busy = busy_q;
    assign div_done = done_q;
    assign divzero  = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// Reference results come from signed 64-bit arithmetic (/ and % truncate
// toward zero, remainder follows the dividend), truncated to 32 bits.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_busy;
    logic        div_done;
    logic        divzero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hi        (hi),
        .lo        (lo),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .divzero   (divzero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
    endfunction

    // Called 1 time unit after a rising edge with the divider idle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        int          busy_n;
        logic        seen;
        ref_div(a, b, eq, er);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        // Operands must no longer matter once accepted.
        dividend  = $urandom;
        divisor   = $urandom;
        busy_n    = div_busy ? 1 : 0;
        cyc       = 0;
        seen      = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (div_done) seen = 1'b1;
            else if (div_busy) busy_n++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd33);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, " lo"}, lo, eq);
        chk({tag, " hi"}, hi, er);
        chk({tag, " busy_at_done"}, {31'd0, div_busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_fall"}, {31'd0, div_done}, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   done_n;
        logic seen;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b0;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1;
        chk("reset lo", lo, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset flags", {29'd0, div_busy, div_done, divzero}, 32'd0);
        #11;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic and sign combinations.
        run_div(32'd7, 32'd2, "7/2");
        run_div(-32'sd7, 32'd2, "-7/2");
        chk("-7/2 lo const", lo, 32'hFFFF_FFFD);
        run_div(32'd7, -32'sd2, "7/-2");
        chk("7/-2 hi const", hi, 32'd1);
        run_div(-32'sd7, -32'sd2, "-7/-2");
        chk("-7/-2 hi const", hi, 32'hFFFF_FFFF);
        run_div(32'd7, 32'd2, "7/2 again");

        // Divide by zero: flag only, results held.
        dividend  = 32'd100;
        divisor   = 32'd0;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        chk("dz pulse", {31'd0, divzero}, 32'd1);
        chk("dz busy", {31'd0, div_busy}, 32'd0);
        done_n = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) chk("dz pulse width", {31'd0, divzero}, 32'd0);
            if (div_done || div_busy) done_n++;
        end
        chk("dz no done/busy", 32'(done_n), 32'd0);
        chk("dz lo held", lo, 32'd3);
        chk("dz hi held", hi, 32'd1);

        // Boundaries.
        run_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
        chk("min/-1 lo const", lo, 32'h8000_0000);
        run_div(32'd0, 32'd5, "0/5");
        run_div(32'h8000_0000, 32'd1, "min/1");
        run_div(32'd5, 32'h8000_0000, "5/min");

        // Starts during RUN and FIX are ignored.
        dividend  = 32'd1000;
        divisor   = 32'd7;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        cyc    = 0;
        done_n = 0;
        for (int i = 0; i < 45; i++) begin
            if (cyc == 4 || cyc == 32) begin
                dividend  = 32'd9;
                divisor   = 32'd3;
                div_start = 1'b1;
            end else begin
                div_start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (div_done) begin
                done_n++;
                if (done_n == 1) begin
                    chk("ignore latency", 32'(cyc), 32'd33);
                    chk("ignore lo", lo, 32'd142);
                    chk("ignore hi", hi, 32'd6);
                end
            end
        end
        div_start = 1'b0;
        chk("ignore single done", 32'(done_n), 32'd1);
        run_div(32'd9, 32'd3, "after ignore");

        // Asynchronous reset in the middle of RUN.
        dividend  = 32'd12345;
        divisor   = 32'd67;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("abort lo", lo, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort flags", {29'd0, div_busy, div_done, divzero}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) reset = 1'b1;
            if (div_done) seen = 1'b1;
        end
        chk("abort no done", {31'd0, seen}, 32'd0);
        run_div(32'd50, 32'd5, "50/5");

        // Randomized operands against the reference.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 20));
                1: rb = -32'($urandom_range(1, 20));
                2: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd1;
            run_div(ra, rb, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
